// File: rtl/ring_buffer_sequencer_if.sv
// Control and status bundle between a ring-buffer sequencer and its controller.
interface ring_buffer_sequencer_if #(
  parameter int ADDR_W = 4
) ();
  logic              start;
  logic              hold;
  logic              abort;
  logic              en_load;
  logic [ADDR_W-1:0] addr_w;
  logic [ADDR_W-1:0] addr_r;
  logic              data_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, hold, abort,
    input  en_load, addr_w, addr_r, data_valid, busy, done
  );

  modport slave (
    input  start, hold, abort,
    output en_load, addr_w, addr_r, data_valid, busy, done
  );
endinterface

// File: rtl/ring_buffer_sequencer.sv
// Periodic load-strobe sequencer that walks a ring buffer's write/read pointers
// through a fixed number of load events, with warm-up, hold and abort handling.
module ring_buffer_sequencer #(
  parameter int ADDR_W   = 4,
  parameter int PERIOD   = 8,
  parameter int LOAD_ON  = 2,
  parameter int LOAD_OFF = 4,
  parameter int WARMUP   = 16,
  parameter int TOTAL    = 320
) (
  input logic                    clk,
  input logic                    rst,
  ring_buffer_sequencer_if.slave bus
);

  localparam int PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PH_X = PH_W + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_EVT  = PH_W'(LOAD_OFF - 1);
  localparam logic [PH_X-1:0] PH_ON   = PH_X'(LOAD_ON);
  localparam logic [PH_X-1:0] PH_OFF  = PH_X'(LOAD_OFF);
  localparam logic [9:0]      WARMUP_C = 10'(WARMUP);
  localparam logic [9:0]      TOTAL_C  = 10'(TOTAL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [PH_W-1:0]   phase_r, phase_s;
  logic [9:0]        cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_w_r, addr_w_s;
  logic [ADDR_W-1:0] addr_r_r, addr_r_s;
  logic              dv_r, dv_s;
  logic              en_load_r, en_load_s;
  logic              busy_r, done_r;
  logic              clear_s;

  // Next-state and next-datapath computation
  always_comb begin
    state_s  = state_r;
    phase_s  = phase_r;
    cnt_s    = cnt_r;
    addr_w_s = addr_w_r;
    addr_r_s = addr_r_r;
    dv_s     = dv_r;
    clear_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
          clear_s = 1'b1;
        end else if (bus.start) begin
          state_s = ST_RUN;
          clear_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // abort outranks both hold and a coincident load event
        if (bus.abort) begin
          state_s = ST_IDLE;
          clear_s = 1'b1;
        end else if (bus.hold) begin
          state_s = ST_RUN;
        end else begin
          phase_s = (phase_r == PH_LAST) ? {PH_W{1'b0}} : phase_r + PH_W'(1);
          if (phase_r == PH_EVT) begin
            cnt_s = cnt_r + 10'd1;
            if (addr_w_r == addr_r_r) begin
              addr_r_s = addr_r_r + ADDR_W'(1);
            end else begin
              addr_w_s = addr_w_r + ADDR_W'(1);
              addr_r_s = addr_r_r + ADDR_W'(1);
            end
            if (cnt_s == WARMUP_C) begin
              dv_s = 1'b1;
            end else begin
              dv_s = dv_r;
            end
            if (cnt_s == TOTAL_C) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
          clear_s = 1'b1;
        end else if (bus.start) begin
          state_s = ST_RUN;
          clear_s = 1'b1;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        clear_s = 1'b1;
      end
    endcase

    if (clear_s) begin
      phase_s  = {PH_W{1'b0}};
      cnt_s    = 10'd0;
      addr_w_s = {ADDR_W{1'b0}};
      addr_r_s = {ADDR_W{1'b0}};
      dv_s     = 1'b0;
    end else begin
      dv_s = dv_s;
    end

    en_load_s = (state_s == ST_RUN) && ({1'b0, phase_s} >= PH_ON) && ({1'b0, phase_s} < PH_OFF);
  end

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      phase_r   <= {PH_W{1'b0}};
      cnt_r     <= 10'd0;
      addr_w_r  <= {ADDR_W{1'b0}};
      addr_r_r  <= {ADDR_W{1'b0}};
      dv_r      <= 1'b0;
      en_load_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      phase_r   <= phase_s;
      cnt_r     <= cnt_s;
      addr_w_r  <= addr_w_s;
      addr_r_r  <= addr_r_s;
      dv_r      <= dv_s;
      en_load_r <= en_load_s;
      busy_r    <= (state_s == ST_RUN);
      done_r    <= (state_s == ST_DONE);
    end
  end

  assign bus.en_load    = en_load_r;
  assign bus.addr_w     = addr_w_r;
  assign bus.addr_r     = addr_r_r;
  assign bus.data_valid = dv_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: doc/ring_buffer_sequencer.md
RING_BUFFER_SEQUENCER -- requirements
Module: ring_buffer_sequencer

Interface
REQ-001 Parameter ADDR_W, 4: ring-buffer address width; depth = 2^ADDR_W.
REQ-002 Parameter PERIOD, 8: cycles per load slot; PERIOD >= 4.
REQ-003 Parameter LOAD_ON, 2: first phase in which en_load is high.
REQ-004 Parameter LOAD_OFF, 4: first phase after LOAD_ON in which en_load is low; LOAD_ON < LOAD_OFF <= PERIOD.
REQ-005 Parameter WARMUP, 16: number of load events before data_valid asserts.
REQ-006 Parameter TOTAL, 320: number of load events per run; TOTAL >= WARMUP; TOTAL < 2^10.
REQ-007 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1: synchronous, active-high reset.
REQ-009 Port start, input, 1: begin a run; sampled in IDLE or DONE.
REQ-010 Port hold, input, 1: freeze sequencing while high in RUN.
REQ-011 Port abort, input, 1: terminate the run and return to IDLE.
REQ-012 Port en_load, output, 1: buffer load strobe.
REQ-013 Port addr_w, output, ADDR_W: buffer write address.
REQ-014 Port addr_r, output, ADDR_W: buffer read address.
REQ-015 Port data_valid, output, 1: warm-up complete; buffered data usable.
REQ-016 Port busy, output, 1: high while in RUN.
REQ-017 Port done, output, 1: run finished; high while in DONE.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and DONE, with transitions: IDLE -start-> RUN; RUN -(event count reaches TOTAL)-> DONE; RUN -abort-> IDLE; DONE -start-> RUN; DONE -abort-> IDLE.
REQ-019 Entering RUN SHALL clear the phase counter, event count, addr_w, addr_r and data_valid, so that the first RUN cycle has phase 0.
REQ-020 In RUN with hold=0, the phase SHALL increment every cycle, wrapping from PERIOD-1 to 0; with hold=1, the phase, addresses, event count and en_load SHALL all be frozen.
REQ-021 en_load SHALL be high exactly when state=RUN and LOAD_ON <= phase < LOAD_OFF; it SHALL be low in IDLE and DONE.
REQ-022 A load event SHALL occur on a RUN cycle with hold=0, abort=0 and phase=LOAD_OFF-1, which is the last cycle of the strobe.
REQ-023 On a load event where addr_w==addr_r, only addr_r SHALL increment; otherwise both addresses SHALL increment, modulo 2^ADDR_W.
REQ-024 After the first event, addr_r SHALL therefore always equal addr_w+1 (mod depth), including across the wrap from 15 to 0.
REQ-025 The event count SHALL be 10 bits wide and increment by 1 on each load event.
REQ-026 data_valid SHALL be registered and go high on the cycle after the WARMUP-th event; it SHALL stay high until the next start, abort or rst.
REQ-027 The TOTAL-th event SHALL move the FSM to DONE on the next cycle; done SHALL rise and busy SHALL fall on that cycle, and no further strobes SHALL be issued.
REQ-028 In DONE, addr_w, addr_r and data_valid SHALL hold their final values.
REQ-029 abort SHALL have priority over a load event and over hold on the same cycle: the event is discarded and the next state is IDLE with all outputs at their reset values.
REQ-030 start SHALL be ignored in RUN.
REQ-031 start and abort asserted together in IDLE or DONE SHALL resolve as abort.

Reset
REQ-032 When rst=1 at a clock edge, the next state SHALL be IDLE, with phase=0, event count=0, en_load=0, addr_w=0, addr_r=0, data_valid=0, busy=0 and done=0.
REQ-033 rst SHALL take priority over start, abort and hold, including mid-run and mid-strobe.
REQ-034 No output SHALL depend combinationally on rst.

Verification
REQ-035 Basic timing: start pulse at cycle 0 -> busy=1 from cycle 1; en_load=1 in cycles 3-4 and 11-12; after cycle 4, addr_w=0 and addr_r=1.
REQ-036 Address wrap: run 17 events -> after event 16, addr_w=15 and addr_r=0; after event 17, addr_w=0 and addr_r=1.
REQ-037 Warm-up: data_valid=0 through event 15; data_valid=1 on the cycle after event 16.
REQ-038 Completion: done=1 and busy=0 exactly one cycle after event 320 (cycle 2557); en_load stays 0 for 50 further cycles; a new start restarts from addr 0/0.
REQ-039 Hold: hold=1 during phase 3 for 5 cycles -> en_load stays 1 for those cycles, the event is delayed by 5 cycles, and the event count is unchanged during the hold.
REQ-040 Abort and reset mid-run: abort at phase 3 -> no address update, IDLE next cycle; rst at event 100 -> all outputs 0 next cycle, and start then runs cleanly.
